// File: rtl/c7bcsr_mtimer.sv
// Multi-channel down-counter timer unit for the c7b CSR block.
// Each channel has its own config, counter and sticky pending bit; pending channels feed a fixed-priority interrupt.
module c7bcsr_mtimer #(
  parameter int NCH       = 4,
  parameter int CHW       = 2,
  parameter int TIMER_BIT = 30
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_wen,
  input  logic [CHW-1:0] cfg_sel,
  input  logic [31:0]    cfg_wdata,
  input  logic [31:0]    cfg_mask,
  input  logic           clr_wen,
  input  logic [CHW-1:0] clr_sel,
  input  logic           clr_wdata,
  input  logic [NCH-1:0] ie_mask,
  input  logic [CHW-1:0] rd_sel,
  output logic [31:0]    rd_tcfg,
  output logic [31:0]    rd_tval,
  output logic [NCH-1:0] pend,
  output logic           intr_any,
  output logic [CHW-1:0] intr_id
);

  localparam int CW = TIMER_BIT + 2;

  logic                 en_q   [NCH];
  logic                 per_q  [NCH];
  logic [TIMER_BIT-1:0] iv_q   [NCH];
  logic [CW-1:0]        cnt_q  [NCH];
  logic [NCH-1:0]       pend_q;

  logic                 en_m   [NCH];
  logic                 per_m  [NCH];
  logic [TIMER_BIT-1:0] iv_m   [NCH];
  logic                 load   [NCH];
  logic                 clr    [NCH];
  logic                 fire   [NCH];

  // Merged config values are used directly at the load edge, so they are computed here.
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      load[i]  = cfg_wen && (cfg_sel == CHW'(i));
      clr[i]   = clr_wen && clr_wdata && (clr_sel == CHW'(i));
      en_m[i]  = (en_q[i] & ~cfg_mask[0]) | (cfg_wdata[0] & cfg_mask[0]);
      per_m[i] = (per_q[i] & ~cfg_mask[1]) | (cfg_wdata[1] & cfg_mask[1]);
      iv_m[i]  = (iv_q[i] & ~cfg_mask[CW-1:2]) | (cfg_wdata[CW-1:2] & cfg_mask[CW-1:2]);
      fire[i]  = !load[i] && en_q[i] && (cnt_q[i] == CW'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        en_q[i]  <= 1'b0;
        per_q[i] <= 1'b0;
        iv_q[i]  <= '0;
        cnt_q[i] <= '0;
      end
      pend_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (load[i]) begin
          en_q[i]  <= en_m[i];
          per_q[i] <= per_m[i];
          iv_q[i]  <= iv_m[i];
          cnt_q[i] <= {iv_m[i], 2'b00};
        end else if (en_q[i] && (cnt_q[i] != '0)) begin
          if (cnt_q[i] == CW'(1))
            cnt_q[i] <= per_q[i] ? {iv_q[i], 2'b00} : '0;
          else
            cnt_q[i] <= cnt_q[i] - CW'(1);
        end
        // A fire on the same edge as a clear wins.
        pend_q[i] <= fire[i] | (pend_q[i] & ~clr[i]);
      end
    end
  end

  always_comb begin
    rd_tcfg = '0;
    rd_tval = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_sel == CHW'(i)) begin
        rd_tcfg = 32'({iv_q[i], per_q[i], en_q[i]});
        rd_tval = 32'(cnt_q[i]);
      end
    end
  end

  logic [NCH-1:0] active;

  // Descending scan so the lowest-numbered active channel is the one left in intr_id.
  always_comb begin
    active   = pend_q & ie_mask;
    intr_any = |active;
    intr_id  = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (active[i]) intr_id = CHW'(i);
    end
  end

  assign pend = pend_q;

  generate
    if (CW < 32) begin : g_hi_bits
      logic unused_hi;
      assign unused_hi = ^{cfg_wdata[31:CW], cfg_mask[31:CW]};
    end
  endgenerate

endmodule

// File: tb/tb_c7bcsr_mtimer.sv
// Directed self-checking bench for c7bcsr_mtimer.
// CHW is widened to 3 so that out-of-range channel selects (>= NCH) can be exercised.
module tb_c7bcsr_mtimer;

  localparam int NCH = 4;
  localparam int CHW = 3;
  localparam int TIMER_BIT = 30;
  localparam logic [31:0] ALL = 32'hFFFF_FFFF;

  logic           clk;
  logic           rst;
  logic           cfg_wen;
  logic [CHW-1:0] cfg_sel;
  logic [31:0]    cfg_wdata;
  logic [31:0]    cfg_mask;
  logic           clr_wen;
  logic [CHW-1:0] clr_sel;
  logic           clr_wdata;
  logic [NCH-1:0] ie_mask;
  logic [CHW-1:0] rd_sel;
  logic [31:0]    rd_tcfg;
  logic [31:0]    rd_tval;
  logic [NCH-1:0] pend;
  logic           intr_any;
  logic [CHW-1:0] intr_id;

  int checks = 0;
  int errors = 0;

  c7bcsr_mtimer #(.NCH(NCH), .CHW(CHW), .TIMER_BIT(TIMER_BIT)) dut (
    .clk(clk), .rst(rst),
    .cfg_wen(cfg_wen), .cfg_sel(cfg_sel), .cfg_wdata(cfg_wdata), .cfg_mask(cfg_mask),
    .clr_wen(clr_wen), .clr_sel(clr_sel), .clr_wdata(clr_wdata),
    .ie_mask(ie_mask), .rd_sel(rd_sel),
    .rd_tcfg(rd_tcfg), .rd_tval(rd_tval), .pend(pend),
    .intr_any(intr_any), .intr_id(intr_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Inputs change at the falling edge and are sampled by the DUT at the next rising edge.
  task automatic step(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [CHW-1:0] sel, input logic [31:0] wdata, input logic [31:0] mask);
    cfg_wen = 1'b1; cfg_sel = sel; cfg_wdata = wdata; cfg_mask = mask;
    step(1);
    cfg_wen = 1'b0; cfg_wdata = '0; cfg_mask = '0;
  endtask

  task automatic clearPend(input logic [CHW-1:0] sel);
    clr_wen = 1'b1; clr_sel = sel; clr_wdata = 1'b1;
    step(1);
    clr_wen = 1'b0; clr_wdata = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cfg_wen = 1'b0; cfg_sel = '0; cfg_wdata = '0; cfg_mask = '0;
    clr_wen = 1'b0; clr_sel = '0; clr_wdata = 1'b0; ie_mask = '0; rd_sel = '0;
    step(2);
    checkOutput("reset_tcfg", rd_tcfg, 32'h0);
    checkOutput("reset_pend", 32'(pend), 32'h0);
    rst = 1'b0;
    step(1);

    $display("[TB] async reset mid-count");
    applyStimulus(0, 32'h9, ALL);
    step(1);
    checkOutput("t1_tval_before", rd_tval, 32'd7);
    checkOutput("t1_tcfg_before", rd_tcfg, 32'h9);
    #2 rst = 1'b1;
    #1;
    checkOutput("t1_tval_rst", rd_tval, 32'h0);
    checkOutput("t1_tcfg_rst", rd_tcfg, 32'h0);
    checkOutput("t1_pend_rst", 32'(pend), 32'h0);
    checkOutput("t1_intr_rst", 32'(intr_any), 32'h0);
    step(1);
    rst = 1'b0;
    step(1);

    $display("[TB] one-shot countdown on ch1");
    rd_sel = 1;
    applyStimulus(1, 32'h5, ALL);
    checkOutput("t2_tval4", rd_tval, 32'd4);
    checkOutput("t2_tcfg", rd_tcfg, 32'h5);
    step(1); checkOutput("t2_tval3", rd_tval, 32'd3);
    step(1); checkOutput("t2_tval2", rd_tval, 32'd2);
    step(1); checkOutput("t2_tval1", rd_tval, 32'd1);
    checkOutput("t2_pend_early", 32'(pend), 32'h0);
    step(1);
    checkOutput("t2_tval0", rd_tval, 32'd0);
    checkOutput("t2_pend_fire", 32'(pend), 32'b0010);
    checkOutput("t2_intr_masked", 32'(intr_any), 32'h0);
    step(20);
    checkOutput("t2_tval_hold", rd_tval, 32'd0);
    checkOutput("t2_pend_hold", 32'(pend), 32'b0010);
    clearPend(1);
    checkOutput("t2_pend_clr", 32'(pend), 32'h0);

    $display("[TB] periodic ch2 with clear");
    rd_sel = 2;
    ie_mask = 4'b0100;
    applyStimulus(2, 32'hB, ALL);
    checkOutput("t3_tval_load", rd_tval, 32'd8);
    step(7);
    checkOutput("t3_tval_e7", rd_tval, 32'd1);
    checkOutput("t3_pend_e7", 32'(pend), 32'h0);
    step(1);
    checkOutput("t3_pend_e8", 32'(pend), 32'b0100);
    checkOutput("t3_tval_e8", rd_tval, 32'd8);
    checkOutput("t3_intr_any", 32'(intr_any), 32'h1);
    checkOutput("t3_intr_id", 32'(intr_id), 32'd2);
    step(1);
    clearPend(2);
    checkOutput("t3_pend_e10", 32'(pend), 32'h0);
    checkOutput("t3_tval_e10", rd_tval, 32'd6);
    step(5);
    checkOutput("t3_pend_e15", 32'(pend), 32'h0);
    step(1);
    checkOutput("t3_pend_e16", 32'(pend), 32'b0100);
    checkOutput("t3_tval_e16", rd_tval, 32'd8);
    applyStimulus(2, 32'h0, ALL);
    checkOutput("t3_pend_after_cfg", 32'(pend), 32'b0100);
    checkOutput("t3_tcfg_off", rd_tcfg, 32'h0);
    clearPend(2);

    $display("[TB] simultaneous fire ch0/ch3");
    ie_mask = 4'b1001;
    applyStimulus(0, 32'h9, ALL);
    step(3);
    applyStimulus(3, 32'h5, ALL);
    step(3);
    checkOutput("t4_pend_early", 32'(pend), 32'h0);
    step(1);
    checkOutput("t4_pend_both", 32'(pend), 32'b1001);
    checkOutput("t4_intr_any", 32'(intr_any), 32'h1);
    checkOutput("t4_intr_id0", 32'(intr_id), 32'd0);
    clearPend(0);
    checkOutput("t4_pend_ch3", 32'(pend), 32'b1000);
    checkOutput("t4_intr_id3", 32'(intr_id), 32'd3);
    ie_mask = 4'b0000;
    #1;
    checkOutput("t4_intr_masked", 32'(intr_any), 32'h0);
    checkOutput("t4_intr_id_masked", 32'(intr_id), 32'd0);
    checkOutput("t4_pend_masked", 32'(pend), 32'b1000);
    step(1);
    clearPend(3);

    $display("[TB] set beats clear, mask-only write");
    rd_sel = 1;
    applyStimulus(1, 32'h5, ALL);
    step(3);
    clearPend(1);
    checkOutput("t5_set_wins", 32'(pend), 32'b0010);
    applyStimulus(1, 32'h0, 32'h1);
    checkOutput("t5_tcfg", rd_tcfg, 32'h4);
    checkOutput("t5_tval_reload", rd_tval, 32'd4);
    checkOutput("t5_pend_kept", 32'(pend), 32'b0010);
    step(2);
    checkOutput("t5_tval_frozen", rd_tval, 32'd4);
    clearPend(1);

    $display("[TB] out-of-range select and INITVAL=0");
    applyStimulus(5, ALL, ALL);
    clr_wen = 1'b1; clr_sel = 5; clr_wdata = 1'b1;
    rd_sel = 5;
    #1;
    checkOutput("t6_rd5_tcfg", rd_tcfg, 32'h0);
    checkOutput("t6_rd5_tval", rd_tval, 32'h0);
    step(1);
    clr_wen = 1'b0; clr_wdata = 1'b0;
    rd_sel = 0; #1;
    checkOutput("t6_ch0_tcfg", rd_tcfg, 32'h9);
    rd_sel = 1; #1;
    checkOutput("t6_ch1_tcfg", rd_tcfg, 32'h4);
    checkOutput("t6_ch1_tval", rd_tval, 32'd4);
    rd_sel = 3; #1;
    checkOutput("t6_ch3_tcfg", rd_tcfg, 32'h5);
    checkOutput("t6_pend", 32'(pend), 32'h0);
    rd_sel = 2;
    applyStimulus(2, 32'h3, ALL);
    step(5);
    checkOutput("t6_iv0_tval", rd_tval, 32'h0);
    checkOutput("t6_iv0_pend", 32'(pend), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/c7bcsr_mtimer.md
Name: c7bcsr_mtimer

Overview:
- Multi-channel timer unit for the c7b CSR block; replaces the single fixed timer behind TCFG/TVAL/TICLR.
- Provides NCH independent down-counters, each with:
  - its own enable, periodic/one-shot mode and initial value;
  - a sticky pending bit;
  - a per-channel interrupt enable.
- Pending channels are reduced to one interrupt line plus the lowest-numbered active channel ID, which feeds ESTAT.IS and ecl.

Parameters:
- NCH, 4, number of timer channels (1..2^CHW).
- CHW, 2, width of channel-select fields.
- TIMER_BIT, 30, width of the INITVAL field. Counter width is TIMER_BIT+2; TIMER_BIT+2 must be <= 32.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- cfg_wen  in  1  configuration write strobe (TCFG write)
- cfg_sel  in  CHW  channel targeted by the cfg write
- cfg_wdata  in  32  bit0 EN, bit1 PERIODIC, bits[TIMER_BIT+1:2] INITVAL
- cfg_mask  in  32  per-bit write mask for cfg_wdata
- clr_wen  in  1  pending-clear strobe (TICLR write)
- clr_sel  in  CHW  channel targeted by the clear
- clr_wdata  in  1  1 clears pending; 0 has no effect
- ie_mask  in  NCH  per-channel interrupt enable
- rd_sel  in  CHW  channel selected for readback
- rd_tcfg  out  32  selected channel config, zero-extended
- rd_tval  out  32  selected channel counter, zero-extended
- pend  out  NCH  raw pending bits (ungated)
- intr_any  out  1  OR of (pend & ie_mask)
- intr_id  out  CHW  lowest index i with pend[i] & ie_mask[i]; 0 when intr_any=0

Behaviour:
- **Reset** (rst asynchronous, high): EN, PERIODIC, INITVAL, counter and pend of every channel go to 0. All outputs read 0.
- **Channel select:** cfg_sel, clr_sel or rd_sel >= NCH: write is ignored; read returns 0.
- **Config write** (cfg_wen, channel c):
  - Each field is updated as (old & ~mask) | (wdata & mask), restricted to its own bits.
  - Every cfg write to c, with any mask, loads counter c with {new INITVAL, 2'b00} at the same edge. The new merged values are used in that cycle, not the latched ones.
  - No decrement happens on a load edge.
- **Counting:** on each edge with EN=1, counter != 0 and no load:
  - counter > 1: counter decrements by 1.
  - counter == 1, one-shot: counter becomes 0 and pend[c] sets.
  - counter == 1, PERIODIC=1: counter reloads {INITVAL, 2'b00} and pend[c] sets.
- **Frozen / idle cases:**
  - EN=0 freezes the counter.
  - counter == 0 with EN=1 stays at 0 and does not fire. This covers one-shot expired and INITVAL=0 in either mode.
- **Latency:** after a load of value N>0 with EN=1, pend rises at the Nth following clock edge.
- **Pending:**
  - pend is sticky; clr_wen & clr_wdata on channel c clears it at the next edge.
  - Set and clear in the same cycle: set wins and pend stays 1.
  - A cfg write does not clear pend.
- **Interrupt outputs:**
  - intr_any and intr_id are combinational from pend and ie_mask.
  - Fixed priority: channel 0 is highest.
  - ie_mask=0 masks the interrupt line but does not stop counting or pend updates.
- **Readback** (combinational, same cycle):
  - rd_tcfg = {0, INITVAL, PERIODIC, EN}.
  - rd_tval = counter value after the last edge.
- **Channel independence:** channels never interact. Simultaneous fires on multiple channels set all of the corresponding pend bits in that edge.

Test Plan:
1. rst pulse mid-count (ch0 EN=1, counter=7) → counter, pend, intr_any, rd_tcfg and rd_tval all 0 immediately, without waiting for clk.
2. cfg write ch1 wdata=0x0000_0005, mask=0xFFFF_FFFF (EN=1, one-shot, INITVAL=1):
   - rd_tval reads 4 on the edge after the write, then 3, 2, 1, 0.
   - pend[1]=1 on the 4th edge after the load.
   - Counter holds at 0; no second fire in the next 20 cycles.
3. ch2 wdata=0x0000_000B (EN=1, PERIODIC=1, INITVAL=2), ie_mask=4'b0100:
   - pend[2] sets at edge 8 after the load; counter reloads to 8.
   - clr at edge 10 clears pend; it re-sets at edge 16.
   - intr_id=2.
4. ch0 and ch3 fire on the same edge, ie_mask=4'b1001 → intr_any=1, intr_id=0. After clearing ch0: intr_id=3. ie_mask=0 → intr_any=0 while pend=4'b1000.
5. Clear on the same edge that ch1 fires → pend[1] stays 1. Mask-only write to ch1 (mask=0x1, wdata=0x0) → EN=0, counter reloads, INITVAL unchanged.
6. cfg_sel=5 with NCH=4 → no channel state changes; rd_sel=5 returns 0.
